// File: rtl/bcd_scan_counter_pkg.sv
// Shared sound-board definitions: BCD widths, run/idle state and the BCD step function.
package bcd_scan_counter_pkg;

   localparam int unsigned BCD_W   = 4;
   localparam int unsigned BCD_MAX = 9;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [BCD_W-1:0] next_q;
      logic             wrapped;
   } bcd_step_t;

   // One up/down step of a decade counter limited to 0..max; illegal codes recover in one step.
   function automatic bcd_step_t next_bcd(input logic [BCD_W-1:0] q,
                                          input logic             up_dn,
                                          input logic [BCD_W-1:0] max);
      bcd_step_t r;
      r.next_q  = q;
      r.wrapped = 1'b0;
      if (up_dn) begin
         if (q == max) begin
            r.next_q  = '0;
            r.wrapped = 1'b1;
         end else if (q > max) begin
            r.next_q = '0;
         end else begin
            r.next_q = q + BCD_W'(1);
         end
      end else begin
         if (q == '0) begin
            r.next_q  = max;
            r.wrapped = 1'b1;
         end else if (q > max) begin
            r.next_q = max;
         end else begin
            r.next_q = q - BCD_W'(1);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_scan_counter.sv
// Decade scan counter driving the 1-of-10 decoder, with optional single-sweep run/idle control.
module bcd_scan_counter
   import bcd_scan_counter_pkg::*;
#(
   parameter int unsigned MAX_COUNT   = BCD_MAX,
   parameter bit          SINGLE_SHOT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             cin,
   input  logic             clr,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   input  logic             up_dn,
   input  logic             start,
   output logic [BCD_W-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             busy,
   output logic             done
);

   localparam logic [BCD_W-1:0] MAX_Q = BCD_W'(MAX_COUNT);

   state_t    state;
   state_t    state_nxt;
   bcd_step_t step_res;
   logic      active;
   logic      count_step;
   logic      wrap_step;

   // Step qualification and the candidate next code.
   always_comb begin
      active     = (state == RUN);
      count_step = active & ce & cin & ~clr & ~load;
      step_res   = next_bcd(q, up_dn, MAX_Q);
      wrap_step  = count_step & step_res.wrapped;
   end

   // Run/idle state register; free-running builds come out of reset already running.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SINGLE_SHOT ? IDLE : RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: clr forces idle, start arms a sweep, the wrapping step ends it.
   always_comb begin
      state_nxt = state;
      if (!SINGLE_SHOT) begin
         state_nxt = RUN;
      end else if (clr) begin
         state_nxt = IDLE;
      end else if (load) begin
         state_nxt = state;
      end else if (state == IDLE) begin
         if (start) begin
            state_nxt = RUN;
         end
      end else if (wrap_step) begin
         state_nxt = IDLE;
      end
   end

   // Status outputs derived from the state register and current code.
   always_comb begin
      busy = (state == RUN);
      tc   = cin & active & (up_dn ? (q == MAX_Q) : (q == '0));
   end

   // Count register plus one-cycle wrap/done pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
         done <= 1'b0;
      end else begin
         wrap <= wrap_step;
         done <= SINGLE_SHOT && wrap_step;
         if (clr) begin
            q <= '0;
         end else if (load) begin
            q <= load_val;
         end else if (count_step) begin
            q <= step_res.next_q;
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: three parameterisations share one stimulus, checked against an arithmetic model.
module tb_bcd_scan_counter;

   localparam int NI = 3;
   localparam int MAXV [NI] = '{9, 5, 9};
   localparam bit SSV  [NI] = '{1'b0, 1'b0, 1'b1};

   logic       clk = 1'b0;
   logic       reset;
   logic       ce, cin, clr, load, up_dn, start;
   logic [3:0] load_val;

   logic [3:0] dq    [NI];
   logic       dtc   [NI];
   logic       dwrap [NI];
   logic       dbusy [NI];
   logic       ddone [NI];

   int checks = 0;
   int errors = 0;

   int mq    [NI];
   bit mrun  [NI];
   bit mwrap [NI];
   bit mdone [NI];

   always #5 clk = ~clk;

   bcd_scan_counter #(.MAX_COUNT(9), .SINGLE_SHOT(1'b0)) u_def (
      .clk(clk), .reset(reset), .ce(ce), .cin(cin), .clr(clr), .load(load),
      .load_val(load_val), .up_dn(up_dn), .start(start),
      .q(dq[0]), .tc(dtc[0]), .wrap(dwrap[0]), .busy(dbusy[0]), .done(ddone[0]));

   bcd_scan_counter #(.MAX_COUNT(5), .SINGLE_SHOT(1'b0)) u_max5 (
      .clk(clk), .reset(reset), .ce(ce), .cin(cin), .clr(clr), .load(load),
      .load_val(load_val), .up_dn(up_dn), .start(start),
      .q(dq[1]), .tc(dtc[1]), .wrap(dwrap[1]), .busy(dbusy[1]), .done(ddone[1]));

   bcd_scan_counter #(.MAX_COUNT(9), .SINGLE_SHOT(1'b1)) u_ss (
      .clk(clk), .reset(reset), .ce(ce), .cin(cin), .clr(clr), .load(load),
      .load_val(load_val), .up_dn(up_dn), .start(start),
      .q(dq[2]), .tc(dtc[2]), .wrap(dwrap[2]), .busy(dbusy[2]), .done(ddone[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         mq[i]    = 0;
         mrun[i]  = !SSV[i];
         mwrap[i] = 1'b0;
         mdone[i] = 1'b0;
      end
   endtask

   // Counter behaviour as modular arithmetic over 0..MAX, with illegal codes snapping to an end.
   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         bit w;
         int m;
         w = 1'b0;
         m = MAXV[i];
         if (clr) begin
            mq[i] = 0;
            if (SSV[i]) mrun[i] = 1'b0;
         end else if (load) begin
            mq[i] = int'(load_val);
         end else if (SSV[i] && !mrun[i] && start) begin
            mrun[i] = 1'b1;
         end else if (mrun[i] && ce && cin) begin
            if (mq[i] > m) begin
               mq[i] = up_dn ? 0 : m;
            end else if (up_dn) begin
               w     = (mq[i] == m);
               mq[i] = (mq[i] + 1) % (m + 1);
            end else begin
               w     = (mq[i] == 0);
               mq[i] = (mq[i] + m) % (m + 1);
            end
            if (w && SSV[i]) mrun[i] = 1'b0;
         end
         mwrap[i] = w;
         mdone[i] = w && SSV[i];
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         bit tce;
         tce = cin && mrun[i] && (up_dn ? (mq[i] == MAXV[i]) : (mq[i] == 0));
         chk($sformatf("i%0d_q", i),    32'(dq[i]),    32'(mq[i]));
         chk($sformatf("i%0d_wrap", i), 32'(dwrap[i]), 32'(mwrap[i]));
         chk($sformatf("i%0d_busy", i), 32'(dbusy[i]), 32'(mrun[i]));
         chk($sformatf("i%0d_done", i), 32'(ddone[i]), 32'(mdone[i]));
         chk($sformatf("i%0d_tc", i),   32'(dtc[i]),   32'(tce));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      ce = 1'b1; cin = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
      up_dn = 1'b1; start = 1'b0;
   endtask

   initial begin
      int done_cnt;
      reset = 1'b1;
      idle_inputs();
      #12;
      model_reset();
      check_all();
      reset = 1'b0;

      // 1: free count up from reset
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("p1_q", 32'(dq[0]), 32'(k % 10));
         chk("p1_tc", 32'(dtc[0]), 32'((k % 10) == 9));
      end

      // 2: ce toggling, with a cin=0 window spanning three enabled ticks
      for (int i = 0; i < 10; i++) begin
         ce  = (i % 2) == 1;
         cin = !(i >= 2 && i <= 7);
         tick();
         if (!cin) chk("p2_tc_low", 32'(dtc[0]), 32'(0));
      end
      idle_inputs();

      // 3: load 7 then count down through wrap; illegal 12 recovers in one step
      load = 1'b1; load_val = 4'd7; tick();
      load = 1'b0; up_dn = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      chk("p3_q9", 32'(dq[0]), 32'(9));
      chk("p3_wrap", 32'(dwrap[0]), 32'(1));
      load = 1'b1; load_val = 4'd12; up_dn = 1'b1; tick();
      load = 1'b0; tick();
      chk("p3_ill_up_q", 32'(dq[0]), 32'(0));
      chk("p3_ill_up_wrap", 32'(dwrap[0]), 32'(0));
      load = 1'b1; tick();
      load = 1'b0; up_dn = 1'b0; tick();
      chk("p3_ill_dn_q", 32'(dq[0]), 32'(9));
      chk("p3_ill_dn_q5", 32'(dq[1]), 32'(5));
      chk("p3_ill_dn_wrap", 32'(dwrap[0]), 32'(0));
      idle_inputs();

      // 4: clr beats load
      clr = 1'b1; load = 1'b1; load_val = 4'd3; tick();
      chk("p4_clr_q", 32'(dq[1]), 32'(0));
      idle_inputs();

      // 5: single sweep with a redundant start mid-sweep
      clr = 1'b1; tick();
      clr = 1'b0; start = 1'b1; tick();
      chk("p5_busy", 32'(dbusy[2]), 32'(1));
      chk("p5_q_hold", 32'(dq[2]), 32'(0));
      start = 1'b0;
      done_cnt = 0;
      for (int k = 1; k <= 14; k++) begin
         start = (k == 5);
         tick();
         if (k <= 10) chk("p5_q", 32'(dq[2]), 32'(k % 10));
         done_cnt += int'(ddone[2]);
      end
      chk("p5_done_cnt", 32'(done_cnt), 32'(1));
      chk("p5_idle", 32'(dbusy[2]), 32'(0));
      idle_inputs();

      // 6: async reset in the middle of a sweep
      clr = 1'b1; tick();
      clr = 1'b0; start = 1'b1; tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("p6_q4", 32'(dq[2]), 32'(4));
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      #2 reset = 1'b0;
      for (int k = 0; k < 12; k++) tick();

      // Randomised operation
      for (int n = 0; n < 600; n++) begin
         ce       = ($urandom % 4) != 0;
         cin      = ($urandom % 5) != 0;
         clr      = ($urandom % 40) == 0;
         load     = ($urandom % 25) == 0;
         load_val = 4'($urandom % 16);
         start    = ($urandom % 15) == 0;
         if (($urandom % 30) == 0) up_dn = ~up_dn;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
